// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl: burst sequencer in front of a single-port synchronous RAM.
// Accepts one burst command at a time and turns it into 1..2**ADDR_W
// consecutive RAM accesses from an incrementing (wrapping) address.
// Write beats come from a valid/ready stream. Read beats are returned as a
// pulse stream qualified by rdata_valid_o, which has no backpressure.
// Optional feature: define RAM_BURST_CTRL_NOWRAP_EN to reject bursts that
// would cross the top of the address space. A rejected burst makes no RAM
// access and answers with done_o and err_o one cycle after the handshake.
module ram_burst_ctrl #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_wr_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [ADDR_W-1:0] cmd_len_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              wdata_valid_i,
  output logic              wdata_ready_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rdata_valid_o,
  output logic              done_o,
  output logic              err_o,
  output logic              ram_en_o,
  output logic              ram_wr_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              rdata_valid_q;

  logic              cmd_ready_s;
  logic              wdata_ready_s;
  logic              ram_en_s;
  logic              ram_wr_s;
  logic [ADDR_W-1:0] ram_addr_s;
  logic [DATA_W-1:0] ram_wdata_s;

`ifdef RAM_BURST_CTRL_NOWRAP_EN
  logic              err_q, err_d;
  // One extra bit catches a burst whose last address runs past the top.
  logic [ADDR_W:0]   span_s;
  assign span_s = {1'b0, cmd_addr_i} + {1'b0, cmd_len_i};
`endif

  // Next-state and RAM-side outputs; reset forces every output quiet so no
  // access is issued in the reset cycle itself.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    done_d        = 1'b0;
`ifdef RAM_BURST_CTRL_NOWRAP_EN
    err_d         = 1'b0;
`endif
    cmd_ready_s   = 1'b0;
    wdata_ready_s = 1'b0;
    ram_en_s      = 1'b0;
    ram_wr_s      = 1'b0;
    ram_addr_s    = ADDR_ZERO;
    ram_wdata_s   = DATA_ZERO;
    if (rst_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cmd_ready_s = 1'b1;
          if (cmd_valid_i) begin
            addr_d = cmd_addr_i;
            cnt_d  = cmd_len_i;
`ifdef RAM_BURST_CTRL_NOWRAP_EN
            if (span_s[ADDR_W]) begin
              // Crossing burst: acknowledge with an error, touch nothing.
              state_d = ST_IDLE;
              done_d  = 1'b1;
              err_d   = 1'b1;
            end else if (cmd_wr_i) begin
              state_d = ST_WRITE;
            end else begin
              state_d = ST_READ;
            end
`else
            if (cmd_wr_i) begin
              state_d = ST_WRITE;
            end else begin
              state_d = ST_READ;
            end
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WRITE: begin
          wdata_ready_s = 1'b1;
          if (wdata_valid_i) begin
            ram_en_s    = 1'b1;
            ram_wr_s    = 1'b1;
            ram_addr_s  = addr_q;
            ram_wdata_s = wdata_i;
            addr_d      = addr_q + ADDR_ONE;
            cnt_d       = cnt_q - ADDR_ONE;
            if (cnt_q == ADDR_ZERO) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_WRITE;
            end
          end else begin
            state_d = ST_WRITE;
          end
        end
        ST_READ: begin
          ram_en_s   = 1'b1;
          ram_addr_s = addr_q;
          addr_d     = addr_q + ADDR_ONE;
          cnt_d      = cnt_q - ADDR_ONE;
          if (cnt_q == ADDR_ZERO) begin
            // Last beat's data returns next cycle, together with done.
            state_d = ST_DRAIN;
            done_d  = 1'b1;
          end else begin
            state_d = ST_READ;
          end
        end
        ST_DRAIN: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, burst counters and the registered status pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      addr_q        <= ADDR_ZERO;
      cnt_q         <= ADDR_ZERO;
      done_q        <= 1'b0;
      rdata_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
      done_q        <= done_d;
      rdata_valid_q <= ram_en_s & ~ram_wr_s;
    end
  end

`ifdef RAM_BURST_CTRL_NOWRAP_EN
  // Error pulse register, only present when crossing bursts are rejected.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign cmd_ready_o   = cmd_ready_s;
  assign wdata_ready_o = wdata_ready_s;
  assign ram_en_o      = ram_en_s;
  assign ram_wr_o      = ram_wr_s;
  assign ram_addr_o    = ram_addr_s;
  assign ram_wdata_o   = ram_wdata_s;
  assign rdata_o       = ram_rdata_i;
  assign rdata_valid_o = rdata_valid_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed self-checking bench for ram_burst_ctrl with a behavioural 64x8
// synchronous RAM attached to its RAM port.
module tb_ram_burst_ctrl;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic              cmd_wr_i;
  logic [ADDR_W-1:0] cmd_addr_i;
  logic [ADDR_W-1:0] cmd_len_i;
  logic [DATA_W-1:0] wdata_i;
  logic              wdata_valid_i;
  logic              wdata_ready_o;
  logic [DATA_W-1:0] rdata_o;
  logic              rdata_valid_o;
  logic              done_o;
  logic              err_o;
  logic              ram_en_o;
  logic              ram_wr_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [DATA_W-1:0] ram_wdata_o;
  logic [DATA_W-1:0] ram_rdata_q;

  logic [DATA_W-1:0] mem [0:63];

  int n_checks = 0;
  int n_fails  = 0;
  int en_cnt   = 0;
  int rv_cnt   = 0;
  int done_cnt = 0;
  logic [ADDR_W-1:0] wr_addr_log [$];
  logic [DATA_W-1:0] wr_data_log [$];
  logic [DATA_W-1:0] rd_log [$];

  ram_burst_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_wr_i(cmd_wr_i),
    .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
    .wdata_i(wdata_i), .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o),
    .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o), .done_o(done_o), .err_o(err_o),
    .ram_en_o(ram_en_o), .ram_wr_o(ram_wr_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_q)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural single-port RAM, read data one cycle after the access.
  always @(posedge clk_i) begin
    if (ram_en_o) begin
      if (ram_wr_o) mem[ram_addr_o] <= ram_wdata_o;
      else          ram_rdata_q     <= mem[ram_addr_o];
    end
  end

  // Mid-cycle monitor: counts pulses and logs RAM writes and returned reads.
  always @(negedge clk_i) begin
    if (ram_en_o) en_cnt <= en_cnt + 1;
    if (ram_en_o && ram_wr_o) begin
      wr_addr_log.push_back(ram_addr_o);
      wr_data_log.push_back(ram_wdata_o);
    end
    if (rdata_valid_o) begin
      rv_cnt <= rv_cnt + 1;
      rd_log.push_back(rdata_o);
    end
    if (done_o) done_cnt <= done_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Write burst of len+1 beats, data base+i, with gap_n idle cycles before beat gap_at.
  task automatic do_write(input logic [5:0] a, input logic [5:0] len, input logic [7:0] base,
                          input int gap_at, input int gap_n);
    int beats;
    int b;
    int gap;
    logic [5:0] ea;
    beats = int'(len) + 1;
    b = 0;
    gap = 0;
    cmd_valid_i = 1'b1; cmd_wr_i = 1'b1; cmd_addr_i = a; cmd_len_i = len;
    #1;
    check_val("wr_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
    tick();
    cmd_valid_i = 1'b0;
    while (b < beats) begin
      if (b == gap_at && gap < gap_n) begin
        wdata_valid_i = 1'b0;
        gap++;
        #1;
        check_val("wr_gap_en", {31'd0, ram_en_o}, 32'd0);
        check_val("wr_gap_ready", {31'd0, wdata_ready_o}, 32'd1);
      end else begin
        wdata_valid_i = 1'b1;
        wdata_i = base + 8'(b);
        ea = a + 6'(b);
        #1;
        check_val("wr_en", {31'd0, ram_en_o}, 32'd1);
        check_val("wr_wr", {31'd0, ram_wr_o}, 32'd1);
        check_val("wr_addr", {26'd0, ram_addr_o}, {26'd0, ea});
        check_val("wr_wdata", {24'd0, ram_wdata_o}, {24'd0, wdata_i});
        b++;
      end
      check_val("wr_busy_ready", {31'd0, cmd_ready_o}, 32'd0);
      check_val("wr_busy_done", {31'd0, done_o}, 32'd0);
      tick();
    end
    wdata_valid_i = 1'b0;
    wdata_i = 8'd0;
    #1;
    check_val("wr_done", {31'd0, done_o}, 32'd1);
    check_val("wr_end_ready", {31'd0, cmd_ready_o}, 32'd1);
    check_val("wr_end_en", {31'd0, ram_en_o}, 32'd0);
    check_val("wr_end_wdata", {24'd0, ram_wdata_o}, 32'd0);
    check_val("wr_err", {31'd0, err_o}, 32'd0);
    tick();
  endtask

  // Read burst of len+1 beats with per-cycle timing checks.
  task automatic do_read(input logic [5:0] a, input logic [5:0] len);
    int n;
    logic [5:0] ea;
    n = int'(len) + 1;
    cmd_valid_i = 1'b1; cmd_wr_i = 1'b0; cmd_addr_i = a; cmd_len_i = len;
    #1;
    check_val("rd_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
    tick();
    cmd_valid_i = 1'b0;
    for (int k = 1; k <= n; k++) begin
      ea = a + 6'(k - 1);
      #1;
      check_val("rd_en", {31'd0, ram_en_o}, 32'd1);
      check_val("rd_wr", {31'd0, ram_wr_o}, 32'd0);
      check_val("rd_addr", {26'd0, ram_addr_o}, {26'd0, ea});
      check_val("rd_busy_ready", {31'd0, cmd_ready_o}, 32'd0);
      check_val("rd_valid", {31'd0, rdata_valid_o}, (k >= 2) ? 32'd1 : 32'd0);
      check_val("rd_early_done", {31'd0, done_o}, 32'd0);
      tick();
    end
    #1;
    check_val("rd_last_valid", {31'd0, rdata_valid_o}, 32'd1);
    check_val("rd_done", {31'd0, done_o}, 32'd1);
    check_val("rd_drain_en", {31'd0, ram_en_o}, 32'd0);
    check_val("rd_drain_ready", {31'd0, cmd_ready_o}, 32'd0);
    tick();
    check_val("rd_end_ready", {31'd0, cmd_ready_o}, 32'd1);
    check_val("rd_end_valid", {31'd0, rdata_valid_o}, 32'd0);
    check_val("rd_end_done", {31'd0, done_o}, 32'd0);
  endtask

  // Safety net so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wi;
    int ri;
    int e0;
    int v0;
    int d0;
    logic [5:0] exp_a [4];
    rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_wr_i = 1'b0; cmd_addr_i = 6'd0; cmd_len_i = 6'd0;
    wdata_i = 8'd0; wdata_valid_i = 1'b0;
    tick();
    tick();
    check_val("rst_en", {31'd0, ram_en_o}, 32'd0);
    check_val("rst_wr", {31'd0, ram_wr_o}, 32'd0);
    check_val("rst_addr", {26'd0, ram_addr_o}, 32'd0);
    check_val("rst_wdata", {24'd0, ram_wdata_o}, 32'd0);
    check_val("rst_rvalid", {31'd0, rdata_valid_o}, 32'd0);
    check_val("rst_done", {31'd0, done_o}, 32'd0);
    check_val("rst_err", {31'd0, err_o}, 32'd0);
    check_val("rst_wready", {31'd0, wdata_ready_o}, 32'd0);
    rst_i = 1'b0;
    #1;
    check_val("post_rst_ready", {31'd0, cmd_ready_o}, 32'd1);
    tick();

    // Single-beat write then read back.
    wi = wr_addr_log.size();
    do_write(6'h0A, 6'd0, 8'hAA, -1, 0);
    check_val("t1_wr_count", wr_addr_log.size() - wi, 32'd1);
    ri = rd_log.size();
    do_read(6'h0A, 6'd0);
    check_val("t1_rd_data", {24'd0, rd_log[ri]}, 32'h0000_00AA);

    // Four-beat write with a two-cycle stall after the first beat.
    wi = wr_addr_log.size();
    d0 = done_cnt;
    do_write(6'h0C, 6'd3, 8'h10, 1, 2);
    check_val("t2_done_count", done_cnt - d0, 32'd1);
    check_val("t2_wr_count", wr_addr_log.size() - wi, 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_val("t2_wr_log_addr", {26'd0, wr_addr_log[wi+i]}, 32'h0C + i);
      check_val("t2_wr_log_data", {24'd0, wr_data_log[wi+i]}, 32'h10 + i);
    end
    ri = rd_log.size();
    do_read(6'h0C, 6'd3);
    for (int i = 0; i < 4; i++) begin
      check_val("t2_rd_data", {24'd0, rd_log[ri+i]}, 32'h10 + i);
    end

    // Burst crossing the top of the address space.
`ifdef RAM_BURST_CTRL_NOWRAP_EN
    e0 = en_cnt;
    cmd_valid_i = 1'b1; cmd_wr_i = 1'b1; cmd_addr_i = 6'h3E; cmd_len_i = 6'd3;
    wdata_valid_i = 1'b1; wdata_i = 8'h55;
    #1;
    check_val("t3_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
    tick();
    cmd_valid_i = 1'b0;
    #1;
    check_val("t3_done", {31'd0, done_o}, 32'd1);
    check_val("t3_err", {31'd0, err_o}, 32'd1);
    check_val("t3_ready", {31'd0, cmd_ready_o}, 32'd1);
    check_val("t3_wready", {31'd0, wdata_ready_o}, 32'd0);
    check_val("t3_en", {31'd0, ram_en_o}, 32'd0);
    wdata_valid_i = 1'b0; wdata_i = 8'd0;
    tick();
    check_val("t3_err_clear", {31'd0, err_o}, 32'd0);
    check_val("t3_no_access", en_cnt - e0, 32'd0);
`else
    exp_a[0] = 6'h3E; exp_a[1] = 6'h3F; exp_a[2] = 6'h00; exp_a[3] = 6'h01;
    wi = wr_addr_log.size();
    do_write(6'h3E, 6'd3, 8'h20, -1, 0);
    for (int i = 0; i < 4; i++) begin
      check_val("t3_wrap_addr", {26'd0, wr_addr_log[wi+i]}, {26'd0, exp_a[i]});
    end
    ri = rd_log.size();
    do_read(6'h3E, 6'd3);
    for (int i = 0; i < 4; i++) begin
      check_val("t3_wrap_data", {24'd0, rd_log[ri+i]}, 32'h20 + i);
    end
`endif

    // Full 64-beat read burst.
    v0 = rv_cnt;
    ri = rd_log.size();
    do_read(6'h00, 6'd63);
    check_val("t4_valid_count", rv_cnt - v0, 32'd64);
    check_val("t4_data_0a", {24'd0, rd_log[ri+10]}, 32'h0000_00AA);
    check_val("t4_data_0f", {24'd0, rd_log[ri+15]}, 32'h0000_0013);
`ifndef RAM_BURST_CTRL_NOWRAP_EN
    check_val("t4_data_00", {24'd0, rd_log[ri+0]}, 32'h0000_0022);
    check_val("t4_data_3f", {24'd0, rd_log[ri+63]}, 32'h0000_0021);
`endif

    // Reset during the third beat of a five-beat read.
    cmd_valid_i = 1'b1; cmd_wr_i = 1'b0; cmd_addr_i = 6'h0C; cmd_len_i = 6'd4;
    tick();
    cmd_valid_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    check_val("t5_ready", {31'd0, cmd_ready_o}, 32'd1);
    check_val("t5_valid_dropped", {31'd0, rdata_valid_o}, 32'd0);
    e0 = en_cnt; v0 = rv_cnt; d0 = done_cnt;
    for (int i = 0; i < 6; i++) tick();
    check_val("t5_no_en", en_cnt - e0, 32'd0);
    check_val("t5_no_valid", rv_cnt - v0, 32'd0);
    check_val("t5_no_done", done_cnt - d0, 32'd0);

    // Command held valid while a write burst is busy.
    cmd_valid_i = 1'b1; cmd_wr_i = 1'b1; cmd_addr_i = 6'h20; cmd_len_i = 6'd1;
    #1;
    check_val("t6_first_ready", {31'd0, cmd_ready_o}, 32'd1);
    tick();
    cmd_wr_i = 1'b0; cmd_addr_i = 6'h20; cmd_len_i = 6'd1;
    wdata_valid_i = 1'b1; wdata_i = 8'h30;
    #1;
    check_val("t6_busy_ready_1", {31'd0, cmd_ready_o}, 32'd0);
    tick();
    wdata_i = 8'h31;
    #1;
    check_val("t6_busy_ready_2", {31'd0, cmd_ready_o}, 32'd0);
    check_val("t6_busy_rd_en", {31'd0, ram_wr_o}, 32'd1);
    tick();
    wdata_valid_i = 1'b0; wdata_i = 8'd0;
    #1;
    check_val("t6_done", {31'd0, done_o}, 32'd1);
    check_val("t6_second_ready", {31'd0, cmd_ready_o}, 32'd1);
    tick();
    cmd_valid_i = 1'b0;
    #1;
    check_val("t6_rd_en", {31'd0, ram_en_o}, 32'd1);
    check_val("t6_rd_wr", {31'd0, ram_wr_o}, 32'd0);
    check_val("t6_rd_addr", {26'd0, ram_addr_o}, 32'h20);
    tick();
    check_val("t6_rd_valid0", {31'd0, rdata_valid_o}, 32'd1);
    check_val("t6_rd_data0", {24'd0, rdata_o}, 32'h30);
    tick();
    check_val("t6_rd_data1", {24'd0, rdata_o}, 32'h31);
    check_val("t6_rd_done", {31'd0, done_o}, 32'd1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end
endmodule
